// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Purpose: Shared AES definitions: state/byte types, the FIPS-197 inverse
//          S-box table, the state byte count and the InvSubBytes FSM encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

   typedef logic [127:0] aes_state_t;
   typedef logic [7:0]   aes_byte_t;

   localparam int AES_STATE_BYTES = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } isb_state_t;

   // FIPS-197 inverse S-box, row = high nibble, column = low nibble.
   localparam aes_byte_t INV_SBOX_TABLE [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage : aes_pkg

`default_nettype wire

// File: rtl/inv_sbox.sv
// ============================================================================
// Module : inv_sbox
// Purpose: Combinational 8-bit AES inverse S-box lookup.
// Ports  : byte_i - input byte
//          byte_o - InvSbox(byte_i)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] byte_i,
   output logic [7:0] byte_o
);

   assign byte_o = INV_SBOX_TABLE[byte_i];

endmodule : inv_sbox

`default_nettype wire

// File: rtl/inv_sub_bytes_seq.sv
// ============================================================================
// Module : inv_sub_bytes_seq
// Purpose: Iterative AES InvSubBytes. Substitutes LANES bytes per cycle of a
//          128-bit state held in a working register; 16/LANES cycles/state.
// Ports  : clk, rst          - clock, asynchronous active-high reset
//          in_valid/in_ready - input handshake, state_in sampled on transfer
//          state_in          - input state, byte i at [8i+7:8i]
//          out_valid/out_ready - output handshake
//          state_out         - substituted state (working register)
//          busy              - high while BUSY or DONE
// Option : INV_SUB_BYTES_SBOX_REG_EN - registers lookup outputs; each group
//          is written back one cycle after lookup (one extra BUSY cycle).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_sub_bytes_seq
   import aes_pkg::*;
#(
   parameter int LANES = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  aes_state_t state_in,
   output logic       out_valid,
   input  logic       out_ready,
   output aes_state_t state_out,
   output logic       busy
);

   localparam int N  = AES_STATE_BYTES / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   generate
      if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
         $fatal(1, "inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   isb_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   aes_state_t       work_q, work_d;

   aes_byte_t        lut_in  [LANES];
   aes_byte_t        lut_out [LANES];

   // Write-back port: which group, its substituted bytes, and whether to write
   aes_byte_t        wb_data [LANES];
   logic [CW-1:0]    wb_idx;
   logic             wb_vld;
   logic             wb_last;

   // Lane l always serves byte cnt*LANES + l of the current group
   generate
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         assign lut_in[l] = work_q[8*(int'(cnt_q)*LANES + l) +: 8];
         inv_sbox u_inv_sbox (
            .byte_i (lut_in[l]),
            .byte_o (lut_out[l])
         );
      end
   endgenerate

`ifdef INV_SUB_BYTES_SBOX_REG_EN
   aes_byte_t     wb_data_q [LANES];
   logic [CW-1:0] wb_idx_q;
   logic          wb_vld_q;
   logic          look_done_q;   // all N groups have been looked up

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int l = 0; l < LANES; l++) wb_data_q[l] <= '0;
         wb_idx_q    <= '0;
         wb_vld_q    <= 1'b0;
         look_done_q <= 1'b0;
      end else if (state_q == ST_BUSY) begin
         wb_data_q   <= lut_out;
         wb_idx_q    <= cnt_q;
         // cnt wraps after the last group; suppress the stray re-lookup
         wb_vld_q    <= !look_done_q;
         look_done_q <= look_done_q | (cnt_q == CNT_LAST);
      end else begin
         wb_vld_q    <= 1'b0;
         look_done_q <= 1'b0;
      end
   end

   assign wb_data = wb_data_q;
   assign wb_idx  = wb_idx_q;
   assign wb_vld  = wb_vld_q;
`else
   assign wb_data = lut_out;
   assign wb_idx  = cnt_q;
   assign wb_vld  = (state_q == ST_BUSY);
`endif

   assign wb_last = wb_vld && (wb_idx == CNT_LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_BUSY;
               cnt_d   = '0;
               work_d  = state_in;
            end
         end
         ST_BUSY: begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
            if (wb_last) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (wb_vld) begin
         for (int i = 0; i < AES_STATE_BYTES; i++) begin
            if (i / LANES == int'(wb_idx)) work_d[8*i +: 8] = wb_data[i % LANES];
         end
      end
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
      state_out = work_q;
   end

endmodule : inv_sub_bytes_seq

`default_nettype wire
